// File: rtl/rresp_arbiter_m8.sv
// -----------------------------------------------------------------------------
// rresp_arbiter_m8
//
// Read-response arbiter for master port 0. Eight slave R channels
// (0 DMA, 1 SPI, 2 I2C, 3 FLASH_NAND, 4 FLASH_NOR, 5 PCIe, 6 ETHERNET, 7 DDR3)
// compete for the single master R channel. One slave is granted per read burst
// in round-robin order. The grant is held until the burst's last beat
// handshakes, or until the beat limit is hit.
//
// Parameters
//   MASTER_ID  rid[3:2] value that marks a response as belonging to this master
//   MAX_BEATS  beat limit per burst (2..256) before an overrun is declared
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   s_axi_r*            packed slave R channels, slave i in lane i
//   s_axi_rready        per-slave ready; only the granted lane ever sees ready
//   m00_axi_r*          master R channel (all zero while idle)
//   grant_idx           granted slave, meaningful while busy
//   busy                a burst is in progress
//   beat_cnt            beats accepted so far in the current burst
//   err_overrun         sticky; a burst ran past MAX_BEATS without rlast
// -----------------------------------------------------------------------------
module rresp_arbiter_m8 #(
  parameter logic [1:0]  MASTER_ID = 2'd0,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic         clk,
  input  logic         reset,

  input  logic [31:0]  s_axi_rid,
  input  logic [255:0] s_axi_rdata,
  input  logic [15:0]  s_axi_rresp,
  input  logic [7:0]   s_axi_rlast,
  input  logic [7:0]   s_axi_rvalid,
  output logic [7:0]   s_axi_rready,

  output logic [3:0]   m00_axi_rid,
  output logic [31:0]  m00_axi_rdata,
  output logic [1:0]   m00_axi_rresp,
  output logic         m00_axi_rlast,
  output logic         m00_axi_rvalid,
  input  logic         m00_axi_rready,

  output logic [2:0]   grant_idx,
  output logic         busy,
  output logic [7:0]   beat_cnt,
  output logic         err_overrun
);

  localparam int unsigned NUM_SLAVES = 8;

  // beat_cnt value seen on the last legal beat of a burst
  localparam logic [7:0] LAST_BEAT_CNT = 8'(MAX_BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  state_t     state, state_nxt;
  logic [2:0] grant_nxt;
  logic [2:0] rr_ptr, rr_nxt;
  logic [7:0] beat_nxt;
  logic       err_nxt;

  // Slave lanes unpacked so the granted lane can be selected by index
  logic [3:0]  rid_arr   [NUM_SLAVES];
  logic [31:0] rdata_arr [NUM_SLAVES];
  logic [1:0]  rresp_arr [NUM_SLAVES];
  logic [7:0]  req;

  logic  gnt_valid;
  logic  gnt_last;
  logic  handshake;
  logic  overrun;
  logic  burst_end;
  pick_t idle_pick;
  pick_t end_pick;

  // First set bit of vec, searching upward from ptr modulo 8. The loop runs
  // from the farthest offset down so the nearest requester is written last.
  function automatic pick_t rr_pick(input logic [7:0] vec, input logic [2:0] ptr);
    pick_t      p;
    logic [2:0] idx;
    p = '0;
    for (int off = NUM_SLAVES - 1; off >= 0; off--) begin
      idx = ptr + 3'(off);
      if (vec[idx]) begin
        p.found = 1'b1;
        p.idx   = idx;
      end
    end
    return p;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rid_arr[i]   = s_axi_rid[4*i +: 4];
      rdata_arr[i] = s_axi_rdata[32*i +: 32];
      rresp_arr[i] = s_axi_rresp[2*i +: 2];
      // Only responses tagged with this master's ID may compete
      req[i]       = s_axi_rvalid[i] && (s_axi_rid[4*i+2 +: 2] == MASTER_ID);
    end
  end

  assign busy      = (state == BURST);
  assign gnt_valid = s_axi_rvalid[grant_idx];
  assign gnt_last  = s_axi_rlast[grant_idx];
  assign handshake = busy && gnt_valid && m00_axi_rready;
  assign overrun   = handshake && !gnt_last && (beat_cnt == LAST_BEAT_CNT);
  assign burst_end = handshake && (gnt_last || overrun);

  // Fresh arbitration from idle uses the stored pointer. At burst end the
  // pointer has not been written yet, so the post-burst search starts at
  // grant_idx+1 directly and the finishing slave is masked out; this is what
  // lets the next burst start with no bubble cycle.
  assign idle_pick = rr_pick(req, rr_ptr);
  assign end_pick  = rr_pick(req & ~(8'd1 << grant_idx), grant_idx + 3'd1);

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_idx;
    rr_nxt         = rr_ptr;
    beat_nxt       = beat_cnt;
    err_nxt        = err_overrun;
    m00_axi_rid    = '0;
    m00_axi_rdata  = '0;
    m00_axi_rresp  = '0;
    m00_axi_rlast  = 1'b0;
    m00_axi_rvalid = 1'b0;
    s_axi_rready   = '0;

    case (state)
      IDLE: begin
        if (idle_pick.found) begin
          state_nxt = BURST;
          grant_nxt = idle_pick.idx;
          beat_nxt  = '0;
        end
      end

      BURST: begin
        // Steering is purely combinational through the registered grant, so
        // each beat passes with no added latency.
        m00_axi_rid             = rid_arr[grant_idx];
        m00_axi_rdata           = rdata_arr[grant_idx];
        m00_axi_rresp           = rresp_arr[grant_idx];
        m00_axi_rlast           = gnt_last;
        m00_axi_rvalid          = gnt_valid;
        s_axi_rready[grant_idx] = m00_axi_rready;

        if (handshake) begin
          beat_nxt = beat_cnt + 8'd1;
        end
        if (overrun) begin
          err_nxt = 1'b1;
        end
        if (burst_end) begin
          rr_nxt = grant_idx + 3'd1;
          if (end_pick.found) begin
            grant_nxt = end_pick.idx;
            beat_nxt  = '0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant_idx   <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_idx   <= grant_nxt;
      rr_ptr      <= rr_nxt;
      beat_cnt    <= beat_nxt;
      err_overrun <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rresp_arbiter_m8.sv
// -----------------------------------------------------------------------------
// tb_rresp_arbiter_m8
//
// Table-driven bench for rresp_arbiter_m8 (MASTER_ID=0, MAX_BEATS=4). Each
// table row is one clock cycle: slave rvalid/rlast/foreign-ID masks and the
// master rready, plus the hand-computed outputs for that cycle. Slave i always
// drives rdata = 32'hD0D0_D000 | i and rresp = i[1:0]; its rid is
// {2'b00, i[1:0]}, or {2'b01, i[1:0]} when marked foreign. Reset checks and
// the asynchronous mid-burst reset are written out by hand.
// -----------------------------------------------------------------------------
module tb_rresp_arbiter_m8;

  localparam int NUM_VECS = 39;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  s_axi_rid;
  logic [255:0] s_axi_rdata;
  logic [15:0]  s_axi_rresp;
  logic [7:0]   s_axi_rlast;
  logic [7:0]   s_axi_rvalid;
  logic [7:0]   s_axi_rready;
  logic [3:0]   m00_axi_rid;
  logic [31:0]  m00_axi_rdata;
  logic [1:0]   m00_axi_rresp;
  logic         m00_axi_rlast;
  logic         m00_axi_rvalid;
  logic         m00_axi_rready;
  logic [2:0]   grant_idx;
  logic         busy;
  logic [7:0]   beat_cnt;
  logic         err_overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rresp_arbiter_m8 #(
    .MASTER_ID (2'd0),
    .MAX_BEATS (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_axi_rid      (s_axi_rid),
    .s_axi_rdata    (s_axi_rdata),
    .s_axi_rresp    (s_axi_rresp),
    .s_axi_rlast    (s_axi_rlast),
    .s_axi_rvalid   (s_axi_rvalid),
    .s_axi_rready   (s_axi_rready),
    .m00_axi_rid    (m00_axi_rid),
    .m00_axi_rdata  (m00_axi_rdata),
    .m00_axi_rresp  (m00_axi_rresp),
    .m00_axi_rlast  (m00_axi_rlast),
    .m00_axi_rvalid (m00_axi_rvalid),
    .m00_axi_rready (m00_axi_rready),
    .grant_idx      (grant_idx),
    .busy           (busy),
    .beat_cnt       (beat_cnt),
    .err_overrun    (err_overrun)
  );

  typedef struct packed {
    logic       rst;     // pulse reset before this row
    logic [7:0] vld;
    logic [7:0] last;
    logic [7:0] frn;     // slaves whose rid carries another master's ID
    logic       mrdy;
    logic       busy;
    logic [2:0] grant;
    logic       mvalid;
    logic       mlast;
    logic [7:0] srdy;
    logic [7:0] beat;
    logic       err;
  } vec_t;

  vec_t vecs [NUM_VECS];

  function automatic vec_t mk(input logic rst, input logic [7:0] vld, input logic [7:0] last,
                              input logic [7:0] frn, input logic mrdy, input logic b,
                              input logic [2:0] g, input logic mv, input logic ml,
                              input logic [7:0] srdy, input logic [7:0] beat, input logic err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.last = last; v.frn = frn; v.mrdy = mrdy;
    v.busy = b; v.grant = g; v.mvalid = mv; v.mlast = ml; v.srdy = srdy;
    v.beat = beat; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] slave_data(input int i);
    return 32'hD0D0_D000 | 32'(i);
  endfunction

  function automatic logic [63:0] pack(input logic b, input logic [2:0] g, input logic mv,
                                       input logic ml, input logic [7:0] srdy,
                                       input logic [3:0] rid, input logic [31:0] d,
                                       input logic [1:0] r, input logic [7:0] beat,
                                       input logic err);
    return {3'b000, b, g, mv, ml, srdy, rid, d, r, beat, err};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] vld, input logic [7:0] last,
                       input logic [7:0] frn, input logic mrdy);
    s_axi_rvalid   = vld;
    s_axi_rlast    = last;
    m00_axi_rready = mrdy;
    for (int i = 0; i < 8; i++) begin
      s_axi_rid[4*i +: 4] = {(frn[i] ? 2'b01 : 2'b00), 2'(i)};
    end
  endtask

  // Entered at posedge+1; drives a row, samples at the falling edge, then
  // returns at the next posedge+1.
  task automatic apply(input int lo, input int hi);
    vec_t        v;
    logic [63:0] e;
    logic [63:0] a;
    for (int k = lo; k < hi; k++) begin
      v = vecs[k];
      if (v.rst) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      drive(v.vld, v.last, v.frn, v.mrdy);
      @(negedge clk);
      e = pack(v.busy, v.busy ? v.grant : 3'd0, v.mvalid, v.mlast, v.srdy,
               v.busy ? {2'b00, v.grant[1:0]} : 4'h0,
               v.busy ? slave_data(int'(v.grant)) : 32'h0,
               v.busy ? v.grant[1:0] : 2'b00,
               v.busy ? v.beat : 8'd0, v.err);
      a = pack(busy, v.busy ? grant_idx : 3'd0, m00_axi_rvalid, m00_axi_rlast, s_axi_rready,
               m00_axi_rid, m00_axi_rdata, m00_axi_rresp,
               v.busy ? beat_cnt : 8'd0, err_overrun);
      check($sformatf("vec%0d", k), a, e);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                  rst  vld    last   frn    rdy busy g     mv ml srdy   beat err
    // Single SPI burst of 4 beats
    vecs[0]  = mk(1'b0, 8'h02, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    vecs[1]  = mk(1'b0, 8'h02, 8'h00, 8'h00, 1, 1, 3'd1, 1, 0, 8'h02, 8'd0, 0);
    vecs[2]  = mk(1'b0, 8'h02, 8'h00, 8'h00, 1, 1, 3'd1, 1, 0, 8'h02, 8'd1, 0);
    vecs[3]  = mk(1'b0, 8'h02, 8'h00, 8'h00, 1, 1, 3'd1, 1, 0, 8'h02, 8'd2, 0);
    vecs[4]  = mk(1'b0, 8'h02, 8'h02, 8'h00, 1, 1, 3'd1, 1, 1, 8'h02, 8'd3, 0);
    vecs[5]  = mk(1'b0, 8'h00, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    // Contention: DMA, I2C, DDR3 valid from reset, 2-beat bursts, order 0,2,7,0
    vecs[6]  = mk(1'b1, 8'h85, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    vecs[7]  = mk(1'b0, 8'h85, 8'h00, 8'h00, 1, 1, 3'd0, 1, 0, 8'h01, 8'd0, 0);
    vecs[8]  = mk(1'b0, 8'h85, 8'h01, 8'h00, 1, 1, 3'd0, 1, 1, 8'h01, 8'd1, 0);
    vecs[9]  = mk(1'b0, 8'h85, 8'h00, 8'h00, 1, 1, 3'd2, 1, 0, 8'h04, 8'd0, 0);
    vecs[10] = mk(1'b0, 8'h85, 8'h04, 8'h00, 1, 1, 3'd2, 1, 1, 8'h04, 8'd1, 0);
    vecs[11] = mk(1'b0, 8'h85, 8'h00, 8'h00, 1, 1, 3'd7, 1, 0, 8'h80, 8'd0, 0);
    vecs[12] = mk(1'b0, 8'h85, 8'h80, 8'h00, 1, 1, 3'd7, 1, 1, 8'h80, 8'd1, 0);
    vecs[13] = mk(1'b0, 8'h85, 8'h00, 8'h00, 1, 1, 3'd0, 1, 0, 8'h01, 8'd0, 0);
    vecs[14] = mk(1'b0, 8'h01, 8'h01, 8'h00, 1, 1, 3'd0, 1, 1, 8'h01, 8'd1, 0);
    vecs[15] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    // Filtering: PCIe response tagged for another master never wins
    vecs[16] = mk(1'b0, 8'h20, 8'h00, 8'h20, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    vecs[17] = mk(1'b0, 8'h20, 8'h00, 8'h20, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    vecs[18] = mk(1'b0, 8'h20, 8'h00, 8'h20, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    // Backpressure and gaps: FLASH_NAND granted, ETHERNET waits
    vecs[19] = mk(1'b0, 8'h08, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    vecs[20] = mk(1'b0, 8'h48, 8'h00, 8'h00, 0, 1, 3'd3, 1, 0, 8'h00, 8'd0, 0);
    vecs[21] = mk(1'b0, 8'h48, 8'h00, 8'h00, 1, 1, 3'd3, 1, 0, 8'h08, 8'd0, 0);
    vecs[22] = mk(1'b0, 8'h40, 8'h00, 8'h00, 1, 1, 3'd3, 0, 0, 8'h08, 8'd1, 0);
    vecs[23] = mk(1'b0, 8'h40, 8'h00, 8'h00, 1, 1, 3'd3, 0, 0, 8'h08, 8'd1, 0);
    vecs[24] = mk(1'b0, 8'h40, 8'h00, 8'h00, 1, 1, 3'd3, 0, 0, 8'h08, 8'd1, 0);
    vecs[25] = mk(1'b0, 8'h48, 8'h00, 8'h00, 0, 1, 3'd3, 1, 0, 8'h00, 8'd1, 0);
    vecs[26] = mk(1'b0, 8'h48, 8'h08, 8'h00, 1, 1, 3'd3, 1, 1, 8'h08, 8'd1, 0);
    vecs[27] = mk(1'b0, 8'h40, 8'h00, 8'h00, 1, 1, 3'd6, 1, 0, 8'h40, 8'd0, 0);
    vecs[28] = mk(1'b0, 8'h40, 8'h40, 8'h00, 1, 1, 3'd6, 1, 1, 8'h40, 8'd1, 0);
    vecs[29] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    // Overrun: FLASH_NOR sends beats with no rlast, limit is 4
    vecs[30] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 0);
    vecs[31] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 1, 3'd4, 1, 0, 8'h10, 8'd0, 0);
    vecs[32] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 1, 3'd4, 1, 0, 8'h10, 8'd1, 0);
    vecs[33] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 1, 3'd4, 1, 0, 8'h10, 8'd2, 0);
    vecs[34] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 1, 3'd4, 1, 0, 8'h10, 8'd3, 0);
    vecs[35] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 1);
    vecs[36] = mk(1'b0, 8'h10, 8'h00, 8'h00, 1, 1, 3'd4, 1, 0, 8'h10, 8'd0, 1);
    vecs[37] = mk(1'b0, 8'h10, 8'h10, 8'h00, 1, 1, 3'd4, 1, 1, 8'h10, 8'd1, 1);
    vecs[38] = mk(1'b0, 8'h00, 8'h00, 8'h00, 1, 0, 3'd0, 0, 0, 8'h00, 8'd0, 1);

    for (int i = 0; i < 8; i++) begin
      s_axi_rdata[32*i +: 32] = slave_data(i);
      s_axi_rresp[2*i +: 2]   = 2'(i);
    end

    // Reset held with every slave presenting a last beat: nothing may pass
    reset = 1'b1;
    drive(8'hFF, 8'hFF, 8'h00, 1'b1);
    @(negedge clk);
    check("reset_outputs",
          pack(busy, grant_idx, m00_axi_rvalid, m00_axi_rlast, s_axi_rready, m00_axi_rid,
               m00_axi_rdata, m00_axi_rresp, beat_cnt, err_overrun), 64'h0);
    check("reset_rr_ptr", 64'(dut.rr_ptr), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    apply(0, 6);
    check("rr_ptr_after_spi", 64'(dut.rr_ptr), 64'd2);
    apply(6, NUM_VECS);

    // Asynchronous reset in the middle of an SPI burst, at beat 2
    drive(8'h02, 8'h00, 8'h00, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
    end
    check("mid_burst_state", {55'h0, busy, grant_idx, beat_cnt[4:0]},
          {55'h0, 1'b1, 3'd1, 5'd2});
    reset = 1'b1;
    #1;
    check("async_reset_outputs",
          pack(busy, grant_idx, m00_axi_rvalid, m00_axi_rlast, s_axi_rready, m00_axi_rid,
               m00_axi_rdata, m00_axi_rresp, beat_cnt, err_overrun), 64'h0);
    check("async_reset_rr_ptr", 64'(dut.rr_ptr), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(8'h00, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
